// File: rtl/fifo_search_pkg.sv
// fifo_search_pkg: shared types and helpers for the searchable FIFO.
package fifo_search_pkg;
    typedef enum logic {IDLE, SCAN} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_search_eng.sv
// fifo_search_eng: sequential masked-key scan over a snapshot of the FIFO window, one entry per cycle.
module fifo_search_eng
    import fifo_search_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  search_req,
    input  logic [DATA_WIDTH-1:0] search_key,
    input  logic [DATA_WIDTH-1:0] search_mask,
    input  logic [ADDR_WIDTH-1:0] head,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  search_busy,
    output logic                  search_done,
    output logic                  search_hit,
    output logic [ADDR_WIDTH-1:0] search_idx
);
    state_t                state;
    logic [DATA_WIDTH-1:0] key, mask;
    logic [ADDR_WIDTH-1:0] base, off;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  match, last;

    // Address wraps naturally modulo the memory depth.
    assign rd_addr     = base + off;
    assign match       = ((rd_data ^ key) & mask) == '0;
    assign last        = {1'b0, off} == cnt - 1'b1;
    assign search_busy = state == SCAN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            key         <= '0;
            mask        <= '0;
            base        <= '0;
            off         <= '0;
            cnt         <= '0;
            search_done <= 1'b0;
            search_hit  <= 1'b0;
            search_idx  <= '0;
        end else begin
            search_done <= 1'b0;
            if (state == IDLE) begin
                if (search_req) begin
                    key        <= search_key;
                    mask       <= search_mask;
                    base       <= head;
                    cnt        <= count;
                    off        <= '0;
                    search_hit <= 1'b0;
                    search_idx <= '0;
                    if (count == '0) search_done <= 1'b1;
                    else state <= SCAN;
                end
            end else if (match || last) begin
                state       <= IDLE;
                search_done <= 1'b1;
                search_hit  <= match;
                search_idx  <= match ? off : '0;
            end else begin
                off <= off + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_search.sv
// fifo_search: synchronous FIFO with level/almost flags, sticky error flags and a content-search engine.
module fifo_search
    import fifo_search_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] wdat,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] rdat,
    output logic                  rvld,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  ovf,
    output logic                  udf,
    input  logic                  search_req,
    input  logic [DATA_WIDTH-1:0] search_key,
    input  logic [DATA_WIDTH-1:0] search_mask,
    output logic                  search_busy,
    output logic                  search_done,
    output logic                  search_hit,
    output logic [ADDR_WIDTH-1:0] search_idx
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AE = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] eng_addr;
    logic                  push, pop;

    assign full         = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) && (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign empty        = wr_ptr == rd_ptr;
    assign level        = wr_ptr - rd_ptr;
    assign almost_full  = level >= AF;
    assign almost_empty = level <= AE;
    assign push         = wren & ~full;
    // Pops are frozen while scanning so the snapshot window cannot move.
    assign pop          = rden & ~empty & ~search_busy;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wdat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdat   <= '0;
            rvld   <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + (ADDR_WIDTH + 1)'(push);
            rd_ptr <= rd_ptr + (ADDR_WIDTH + 1)'(pop);
            rdat   <= pop ? mem[rd_ptr[ADDR_WIDTH-1:0]] : '0;
            rvld   <= pop;
            ovf    <= ovf | (wren & full);
            udf    <= udf | (rden & empty & ~search_busy);
        end
    end

    fifo_search_eng #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_eng (
        .clk         (clk),
        .rst         (rst),
        .search_req  (search_req),
        .search_key  (search_key),
        .search_mask (search_mask),
        .head        (rd_ptr[ADDR_WIDTH-1:0]),
        .count       (level),
        .rd_data     (mem[eng_addr]),
        .rd_addr     (eng_addr),
        .search_busy (search_busy),
        .search_done (search_done),
        .search_hit  (search_hit),
        .search_idx  (search_idx)
    );
endmodule

// File: tb/tb_fifo_search.sv
// tb_fifo_search: directed and randomized checks of fifo_search against a queue-based reference model.
module tb_fifo_search;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        wren = 1'b0, rden = 1'b0, search_req = 1'b0;
    logic [31:0] wdat = '0, search_key = '0, search_mask = '0;
    logic [31:0] rdat;
    logic        rvld, full, empty, almost_full, almost_empty, ovf, udf;
    logic [4:0]  level;
    logic        search_busy, search_done, search_hit;
    logic [3:0]  search_idx;

    fifo_search dut (
        .clk(clk), .rst(rst), .wren(wren), .wdat(wdat), .rden(rden), .rdat(rdat), .rvld(rvld),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .ovf(ovf), .udf(udf), .search_req(search_req), .search_key(search_key),
        .search_mask(search_mask), .search_busy(search_busy), .search_done(search_done),
        .search_hit(search_hit), .search_idx(search_idx)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a queue plus the cycle on which the pending search result is due.
    logic [31:0] q[$];
    bit          m_ovf, m_udf, srch, res_valid, m_hit, pend_hit;
    int          cyc, scan_start, done_at, m_idx, pend_idx;

    function automatic bit m_busy(input int c);
        return srch && c >= scan_start && c < done_at;
    endfunction

    task automatic check_outputs(input bit popped, input logic [31:0] front);
        int n = q.size();
        chk("level", level, n);
        chk("full", full, n == DEPTH);
        chk("empty", empty, n == 0);
        chk("almost_full", almost_full, n >= 12);
        chk("almost_empty", almost_empty, n <= 2);
        chk("ovf", ovf, m_ovf);
        chk("udf", udf, m_udf);
        chk("rvld", rvld, popped);
        chk("rdat", rdat, popped ? front : 32'h0);
        chk("busy", search_busy, m_busy(cyc));
        chk("done", search_done, srch && cyc == done_at);
        if (res_valid) begin
            chk("hit", search_hit, m_hit);
            chk("idx", search_idx, m_idx);
        end
    endtask

    task automatic cycle(input bit we, input logic [31:0] wd, input bit re, input bit sr,
                         input logic [31:0] key, input logic [31:0] mask);
        bit          busy_now, pop_ok, push_ok;
        logic [31:0] front;
        int          n, j;
        wren = we; wdat = wd; rden = re; search_req = sr; search_key = key; search_mask = mask;
        busy_now = m_busy(cyc);
        n = q.size();
        pop_ok = re && n > 0 && !busy_now;
        push_ok = we && n < DEPTH;
        if (we && n == DEPTH) m_ovf = 1;
        if (re && n == 0 && !busy_now) m_udf = 1;
        if (sr && !busy_now) begin
            j = -1;
            for (int i = 0; i < n; i++)
                if (j < 0 && ((q[i] ^ key) & mask) == 0) j = i;
            srch = 1;
            scan_start = cyc + 1;
            done_at = cyc + 1 + (n == 0 ? 0 : (j >= 0 ? j + 1 : n));
            pend_hit = j >= 0;
            pend_idx = j >= 0 ? j : 0;
            res_valid = 0;
        end
        front = n > 0 ? q[0] : 32'h0;
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(wd);
        @(posedge clk);
        #1;
        cyc++;
        wren = 0; rden = 0; search_req = 0;
        if (srch && cyc == done_at) begin
            res_valid = 1;
            m_hit = pend_hit;
            m_idx = pend_idx;
        end
        check_outputs(pop_ok, front);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        m_ovf = 0; m_udf = 0; srch = 0; res_valid = 1; m_hit = 0; m_idx = 0;
        #2;
        check_outputs(0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] d, key, mask;
        int          pw;
        #1;
        do_reset();
        // Fill to full, overflow, drain and underflow.
        for (int i = 0; i < 16; i++) cycle(1, i, 0, 0, 0, 0);
        cycle(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        cycle(1, 32'h1234, 1, 0, 0, 0);
        for (int i = 0; i < 17; i++) cycle(0, 0, 1, 0, 0, 0);
        cycle(1, 32'hA5A5_0000, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        idle(1);
        // Pointer wrap.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 100 + i, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(1, 200 + i, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 1, 0, 0, 0);
        // Searches: hit, masked miss with ignored rden/req during scan, empty FIFO.
        cycle(0, 0, 0, 1, 32'h5, '1);
        foreach (d[i]) if (i < 4) cycle(1, 10 * (i + 1), 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 32'd30, 32'hFFFF_FFFF);
        idle(4);
        cycle(0, 0, 0, 1, 32'h99, 32'hFF);
        cycle(0, 0, 1, 1, 32'd10, '1);
        idle(5);
        // Reset in the middle of a scan.
        cycle(0, 0, 0, 1, 32'h99, 32'hFF);
        idle(2);
        do_reset();
        idle(3);
        // Randomized traffic with push-heavy, balanced and pop-heavy phases.
        for (int p = 0; p < 6; p++) begin
            pw = (p % 3 == 0) ? 75 : (p % 3 == 1) ? 50 : 25;
            for (int i = 0; i < 400; i++) begin
                d = $urandom_range(1) ? 32'($urandom_range(7)) : $urandom;
                key = (q.size() > 0 && $urandom_range(1)) ? q[$urandom_range(q.size() - 1)] : $urandom;
                mask = $urandom_range(1) ? 32'hFFFF_FFFF : $urandom;
                cycle($urandom_range(99) < pw, d, $urandom_range(99) < 100 - pw,
                      $urandom_range(99) < 8, key, mask);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
